// File: rtl/alu_issue.sv
// alu_issue: decodes one RV32I ALU/branch/load-store instruction, drives an external ALU
// through registered operands, and returns the write-back/branch bundle over a handshake.
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef REG_ADDR_LEN
`define REG_ADDR_LEN 5
`endif
`ifndef ALU_ADD
`define ALU_ADD   4'd0
`define ALU_SUB   4'd1
`define ALU_AND   4'd2
`define ALU_OR    4'd3
`define ALU_XOR   4'd4
`define ALU_SLL   4'd5
`define ALU_SRL   4'd6
`define ALU_SRA   4'd7
`define ALU_SLT   4'd8
`define ALU_SLTU  4'd9
`define ALU_LW_SW 4'd10
`endif

module alu_issue (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                instr,
    input  logic [`DATA_LEN-1:0]       rs1_data,
    input  logic [`DATA_LEN-1:0]       rs2_data,
    output logic [`DATA_LEN-1:0]       alu_a,
    output logic [`DATA_LEN-1:0]       alu_b,
    output logic [3:0]                 alu_op,
    output logic [4:0]                 alu_shamt,
    input  logic [`DATA_LEN-1:0]       alu_result,
    input  logic                       alu_zero,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [`DATA_LEN-1:0]       wb_data,
    output logic [`REG_ADDR_LEN-1:0]   wb_rd,
    output logic                       wb_en,
    output logic                       br_taken,
    output logic                       illegal
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                     r_state, w_next;
    logic [`DATA_LEN-1:0]       r_alu_a, r_alu_b, r_wb_data;
    logic [3:0]                 r_alu_op;
    logic [4:0]                 r_alu_shamt;
    logic [`REG_ADDR_LEN-1:0]   r_wb_rd, r_pend_rd;
    logic                       r_wb_en, r_br, r_ill, r_pend_en, r_beq, r_bne;

    logic [6:0]                 w_opc, w_f7;
    logic [2:0]                 w_f3;
    logic [`REG_ADDR_LEN-1:0]   w_rd;
    logic [`DATA_LEN-1:0]       w_imm_i, w_imm_s, w_a, w_b;
    logic [3:0]                 w_op;
    logic [4:0]                 w_shamt;
    logic                       w_legal, w_wen, w_beq, w_bne, w_shift, w_accept, w_unused;

    assign w_opc    = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_f7     = instr[31:25];
    assign w_rd     = instr[11:7];
    assign w_imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_shift  = (w_f3 == 3'b001) || (w_f3 == 3'b101);
    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_unused = &{1'b0, instr[19:15]};

    function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f3_op = alt ? `ALU_SUB : `ALU_ADD;
            3'b111:  f3_op = `ALU_AND;
            3'b110:  f3_op = `ALU_OR;
            3'b100:  f3_op = `ALU_XOR;
            3'b001:  f3_op = `ALU_SLL;
            3'b101:  f3_op = alt ? `ALU_SRA : `ALU_SRL;
            3'b010:  f3_op = `ALU_SLT;
            default: f3_op = `ALU_SLTU;
        endcase
    endfunction

    // Shifts take their operand on alu_b so the ALU's shifter sees rs1 on both ports.
    always_comb begin
        w_legal = 1'b0;
        w_op    = `ALU_ADD;
        w_a     = rs1_data;
        w_b     = rs2_data;
        w_shamt = 5'd0;
        w_wen   = 1'b0;
        w_beq   = 1'b0;
        w_bne   = 1'b0;
        case (w_opc)
            7'b0110011: begin
                w_legal = (w_f7 == 7'd0) || (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101));
                w_op    = f3_op(w_f3, w_f7[5]);
                w_wen   = w_rd != '0;
                if (w_shift) begin
                    w_b     = rs1_data;
                    w_shamt = rs2_data[4:0];
                end
            end
            7'b0010011: begin
                w_legal = (w_f3 == 3'b001) ? (w_f7 == 7'd0) :
                          (w_f3 == 3'b101) ? (w_f7 == 7'd0 || w_f7 == 7'b0100000) : 1'b1;
                w_op    = f3_op(w_f3, w_f3 == 3'b101 && w_f7[5]);
                w_b     = w_imm_i;
                w_wen   = w_rd != '0;
                if (w_shift) begin
                    w_b     = rs1_data;
                    w_shamt = instr[24:20];
                end
            end
            7'b0000011: begin
                w_legal = w_f3 == 3'b010;
                w_op    = `ALU_LW_SW;
                w_b     = w_imm_i;
            end
            7'b0100011: begin
                w_legal = w_f3 == 3'b010;
                w_op    = `ALU_LW_SW;
                w_b     = w_imm_s;
            end
            7'b1100011: begin
                w_beq   = w_f3 == 3'b000;
                w_bne   = w_f3 == 3'b001;
                w_legal = w_beq || w_bne;
                w_op    = `ALU_SUB;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? (w_legal ? EXEC : RESP) : IDLE;
            EXEC:    w_next = RESP;
            default: w_next = out_ready ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= `ALU_ADD;
            r_alu_shamt <= '0;
            r_pend_rd   <= '0;
            r_pend_en   <= 1'b0;
            r_beq       <= 1'b0;
            r_bne       <= 1'b0;
            r_wb_data   <= '0;
            r_wb_rd     <= '0;
            r_wb_en     <= 1'b0;
            r_br        <= 1'b0;
            r_ill       <= 1'b0;
        end else begin
            if (w_accept && w_legal) begin
                r_alu_a     <= w_a;
                r_alu_b     <= w_b;
                r_alu_op    <= w_op;
                r_alu_shamt <= w_shamt;
                r_pend_rd   <= w_wen ? w_rd : '0;
                r_pend_en   <= w_wen;
                r_beq       <= w_beq;
                r_bne       <= w_bne;
            end
            // Illegal bundles skip EXEC and leave the ALU drive untouched.
            if (w_accept && !w_legal) begin
                r_wb_data <= '0;
                r_wb_rd   <= '0;
                r_wb_en   <= 1'b0;
                r_br      <= 1'b0;
                r_ill     <= 1'b1;
            end
            if (r_state == EXEC) begin
                r_wb_data <= alu_result;
                r_wb_rd   <= r_pend_rd;
                r_wb_en   <= r_pend_en;
                r_br      <= (r_beq && alu_zero) || (r_bne && !alu_zero);
                r_ill     <= 1'b0;
            end
        end
    end

    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == RESP;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign alu_shamt = r_alu_shamt;
    assign wb_data   = r_wb_data;
    assign wb_rd     = r_wb_rd;
    assign wb_en     = r_wb_en;
    assign br_taken  = r_br;
    assign illegal   = r_ill;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: scoreboard bench for alu_issue with a behavioural ALU closing the loop;
// directed instructions carry hand-computed expected bundles.
module tb_alu_issue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] instr = '0, rs1_data = '0, rs2_data = '0;
    logic        in_ready, out_valid, alu_zero, wb_en, br_taken, illegal;
    logic [31:0] alu_a, alu_b, alu_result, wb_data;
    logic [3:0]  alu_op;
    logic [4:0]  alu_shamt, wb_rd;

    typedef struct packed {
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        en, br, ill;
        logic [3:0]  op;
        logic [31:0] b;
        logic [4:0]  sh;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0, bad = 0;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_en(wb_en), .br_taken(br_taken), .illegal(illegal)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        case (alu_op)
            4'd0:  alu_result = alu_a + alu_b;
            4'd1:  alu_result = alu_a - alu_b;
            4'd2:  alu_result = alu_a & alu_b;
            4'd3:  alu_result = alu_a | alu_b;
            4'd4:  alu_result = alu_a ^ alu_b;
            4'd5:  alu_result = alu_b << alu_shamt;
            4'd6:  alu_result = alu_b >> alu_shamt;
            4'd7:  alu_result = $signed(alu_b) >>> alu_shamt;
            4'd8:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'd9:  alu_result = {31'd0, alu_a < alu_b};
            4'd10: alu_result = alu_a + alu_b;
            default: ;
        endcase
    end
    assign alu_zero = alu_result == '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] wd, input logic [4:0] rd, input logic en, br, ill,
                                input logic [3:0] op, input logic [31:0] b, input logic [4:0] sh);
        mk = '{wd: wd, rd: rd, en: en, br: br, ill: ill, op: op, b: b, sh: sh};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_response: got wb_data %0h with nothing outstanding", wb_data);
            end else begin
                mon_e = q.pop_front();
                chk("wb_data",  wb_data,   mon_e.wd);
                chk("wb_rd",    wb_rd,     mon_e.rd);
                chk("wb_en",    wb_en,     mon_e.en);
                chk("br_taken", br_taken,  mon_e.br);
                chk("illegal",  illegal,   mon_e.ill);
                chk("alu_op",   alu_op,    mon_e.op);
                chk("alu_b",    alu_b,     mon_e.b);
                chk("alu_shamt", alu_shamt, mon_e.sh);
            end
        end
    end

    task automatic issue(input string nm, input logic [31:0] ins, r1, r2, input exp_t e,
                         input int lat, input bit stall);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        instr = ins;
        rs1_data = r1;
        rs2_data = r2;
        in_valid = 1'b1;
        out_ready = !stall;
        q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, "_latency"}, n, lat);
        if (stall) begin
            repeat (3) begin
                @(negedge clk);
                chk("stall_out_valid", out_valid, 1);
                chk("stall_in_ready", in_ready, 0);
                chk("stall_wb_data", wb_data, e.wd);
                chk("stall_wb_rd", wb_rd, e.rd);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
        end
        n = 0;
        while (!in_ready && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, "_return_cycles"}, n, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_illegal", illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue("add",    32'h002081B3, 32'd5,        32'd7,  mk(32'd12,        5'd3, 1, 0, 0, 4'd0,  32'd7,        5'd0),  2, 0);
        issue("srai",   32'h40435293, 32'hFFFFFF00, 32'd0,  mk(32'hFFFFFFF0,  5'd5, 1, 0, 0, 4'd7,  32'hFFFFFF00, 5'd4),  2, 0);
        issue("beq",    32'h00208063, 32'd9,        32'd9,  mk(32'd0,         5'd0, 0, 1, 0, 4'd1,  32'd9,        5'd0),  2, 0);
        issue("bne",    32'h00209063, 32'd9,        32'd9,  mk(32'd0,         5'd0, 0, 0, 0, 4'd1,  32'd9,        5'd0),  2, 0);
        issue("ill_op", 32'h0000007F, 32'd1,        32'd2,  mk(32'd0,         5'd0, 0, 0, 1, 4'd1,  32'd9,        5'd0),  1, 0);
        issue("sub",    32'h40208233, 32'd10,       32'd3,  mk(32'd7,         5'd4, 1, 0, 0, 4'd1,  32'd3,        5'd0),  2, 0);
        issue("sll",    32'h00209333, 32'd3,        32'h24, mk(32'h30,        5'd6, 1, 0, 0, 4'd5,  32'd3,        5'd4),  2, 0);
        issue("addi_x0", 32'hFFF08013, 32'd5,       32'd0,  mk(32'd4,         5'd0, 0, 0, 0, 4'd0,  32'hFFFFFFFF, 5'd0),  2, 0);
        issue("lw",     32'hFFC0A383, 32'h100,      32'd0,  mk(32'hFC,        5'd0, 0, 0, 0, 4'd10, 32'hFFFFFFFC, 5'd0),  2, 0);
        issue("sw",     32'h0020A423, 32'h200,      32'd5,  mk(32'h208,       5'd0, 0, 0, 0, 4'd10, 32'd8,        5'd0),  2, 0);
        issue("ill_mul", 32'h022081B3, 32'd1,       32'd2,  mk(32'd0,         5'd0, 0, 0, 1, 4'd10, 32'd8,        5'd0),  1, 0);
        issue("ill_slli", 32'h40309113, 32'd1,      32'd2,  mk(32'd0,         5'd0, 0, 0, 1, 4'd10, 32'd8,        5'd0),  1, 0);
        issue("slt",    32'h0020A1B3, 32'hFFFFFFFF, 32'd1,  mk(32'd1,         5'd3, 1, 0, 0, 4'd8,  32'd1,        5'd0),  2, 0);
        issue("sltu",   32'h0020B1B3, 32'hFFFFFFFF, 32'd1,  mk(32'd0,         5'd3, 1, 0, 0, 4'd9,  32'd1,        5'd0),  2, 0);
        issue("srl_stall", 32'h0020D1B3, 32'h80000000, 32'd31, mk(32'd1,      5'd3, 1, 0, 0, 4'd6,  32'h80000000, 5'd31), 2, 1);

        @(negedge clk);
        instr = 32'h002081B3;
        rs1_data = 32'd5;
        rs2_data = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_alu_a", alu_a, 0);
        chk("midrst_alu_b", alu_b, 0);
        chk("midrst_alu_op", alu_op, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("midrst_no_result", out_valid, 0);
        end

        issue("add_after_rst", 32'h002081B3, 32'd1, 32'd2, mk(32'd3, 5'd3, 1, 0, 0, 4'd0, 32'd2, 5'd0), 2, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameters: none; data width SHALL be `DATA_LEN (32) and register-address width `REG_ADDR_LEN (5); alu_op codes SHALL be the `ALU_* encodings from defines.v.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1  instruction/operand bundle valid.
REQ-005 in_ready  out  1  block can accept a bundle.
REQ-006 instr  in  32  RV32I instruction word.
REQ-007 rs1_data, rs2_data  in  32 each  register-file read data, sampled with instr.
REQ-008 alu_a, alu_b  out  32 each  registered ALU operands.
REQ-009 alu_op  out  4  registered ALU operation.
REQ-010 alu_shamt  out  5  registered shift amount.
REQ-011 alu_result  in  32 / alu_zero  in  1  ALU response (combinational from alu_a/alu_b/alu_op/alu_shamt).
REQ-012 out_valid  out  1 / out_ready  in  1  result handshake.
REQ-013 wb_data  out  32 / wb_rd  out  5 / wb_en  out  1 / br_taken  out  1 / illegal  out  1  result bundle.

Function
REQ-014 FSM states IDLE, EXEC, RESP; in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==RESP).
REQ-015 IDLE: in_valid&&in_ready -> capture instr/rs1_data/rs2_data, decode, load alu_a/alu_b/alu_op/alu_shamt, go EXEC; illegal decode -> go RESP directly, ALU drive registers unchanged.
REQ-016 EXEC: exactly one cycle; capture alu_result/alu_zero into result registers; go RESP.
REQ-017 RESP: hold all result outputs stable until out_ready; out_valid&&out_ready -> IDLE; no same-cycle acceptance of a new bundle.
REQ-018 Latency: legal bundle accepted at edge N -> out_valid at N+2; illegal -> out_valid at N+1; minimum 3 cycles per legal instruction.
REQ-019 Opcode 0110011 (R): funct7 0000000 with funct3 000/111/110/100/001/101/010/011 -> ADD/AND/OR/XOR/SLL/SRL/SLT/SLTU; funct7 0100000 with funct3 000/101 -> SUB/SRA; any other combination illegal.
REQ-020 Opcode 0010011 (I): same funct3 mapping, alu_b = sign-extended instr[31:20]; funct3 001 requires instr[31:25]=0; funct3 101 instr[31:25] 0000000 -> SRL, 0100000 -> SRA, else illegal.
REQ-021 Shifts (R and I): alu_a = alu_b = rs1_data; alu_shamt = rs2_data[4:0] (R) or instr[24:20] (I); all non-shift ops alu_shamt = 0, alu_a = rs1_data.
REQ-022 Opcode 0000011 funct3 010 (lw) / 0100011 funct3 010 (sw): alu_op=`ALU_LW_SW, alu_b = sign-extended I or S immediate ({instr[31:25],instr[11:7]}); wb_data = address; wb_en = 0; other funct3 illegal.
REQ-023 Opcode 1100011: funct3 000 (beq) / 001 (bne) -> alu_op=`ALU_SUB, alu_b=rs2_data; br_taken = alu_zero (beq) or !alu_zero (bne); other funct3 illegal.
REQ-024 Arithmetic R/I: wb_en = (rd!=0), wb_rd = instr[11:7]; whenever wb_en=0, wb_rd = 0; br_taken = 0 for non-branches.
REQ-025 Illegal: illegal=1, wb_en=0, wb_data=0, wb_rd=0, br_taken=0; any other opcode illegal.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE (in_ready=1, out_valid=0), discard any in-flight bundle, clear alu_a/alu_b/alu_shamt/wb_data/wb_rd/wb_en/br_taken/illegal to 0 and alu_op to `ALU_ADD.
REQ-027 First acceptance possible on the first rising edge after rst_n deasserts.

Verification
REQ-028 instr 0x002081B3 (add x3,x1,x2), rs1=5, rs2=7 -> alu_op `ALU_ADD; out_valid 2 cycles after handshake; wb_data=12, wb_rd=3, wb_en=1.
REQ-029 instr 0x40435293 (srai x5,x6,4), rs1=0xFFFFFF00 -> alu_op `ALU_SRA, alu_b=0xFFFFFF00, alu_shamt=4; wb_data=0xFFFFFFF0.
REQ-030 instr 0x00208063 (beq) rs1=rs2=9 -> br_taken=1, wb_en=0; instr 0x00209063 (bne) same data -> br_taken=0.
REQ-031 instr 0x0000007F -> out_valid 1 cycle after handshake, illegal=1, wb_en=0, alu_op unchanged from prior value.
REQ-032 out_ready held low 3 cycles in RESP -> out_valid=1 and all result outputs constant, in_ready=0; out_ready high -> in_ready=1 next cycle.
REQ-033 rst_n pulsed low during EXEC -> out_valid=0, in_ready=1 asynchronously, no result ever presented for that bundle.
